oh_iobufds_bank: RTL

Parametrised bank of N bidirectional differential pad models with per-channel direction state machines, turnaround guard cycles, registered drive and receive paths, and invalid-pair error detection. It is the multi-channel successor to the single-pair differential I/O buffer model. It sits in the dv behavioural library between pad-level testbench nets and link-layer RTL, such as LVDS-style half-duplex lanes. It is a 4-state simulation model, not synthesisable pad logic.

---
 rtl/oh_iobufds_bank.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/oh_iobufds_bank.sv
// Bank of N half-duplex differential pad models. Each channel owns a direction
// FSM with turnaround guard cycles; only the error counter is shared.
module oh_iobufds_bank #(
  parameter int N     = 8,
  parameter int GUARD = 2,
  parameter int ERRW  = 8
) (
  input  logic            clk,
  input  logic            nreset,
  inout  wire  [N-1:0]    io_p,
  inout  wire  [N-1:0]    io_n,
  input  logic [N-1:0]    tx_req,
  input  logic [N-1:0]    tx_data,
  input  logic            err_clear,
  output logic [N-1:0]    tx_active,
  output logic [N-1:0]    rx_data,
  output logic [N-1:0]    rx_valid,
  output logic [N-1:0]    err_flag,
  output logic [ERRW-1:0] err_count
);

  typedef enum logic [1:0] {
    ST_RX       = 2'd0,
    ST_TX_GUARD = 2'd1,
    ST_TX       = 2'd2,
    ST_RX_GUARD = 2'd3
  } state_t;

  // With GUARD=0 the guard states are never entered, so the compare value is moot.
  localparam logic [3:0] GUARD_LAST = (GUARD == 0) ? 4'd0 : 4'(GUARD - 1);
  localparam bit         HAS_GUARD  = (GUARD != 0);

  logic [N-1:0] err_vec;
  logic         any_err;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ch
      state_t     state_reg, state_next;
      logic [3:0] cnt_reg, cnt_next;
      logic       tx_q_reg;
      logic       rx_data_reg, rx_valid_reg, err_flag_reg;
      logic       drive;
      logic       pair_valid, pair_bit;

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
          ST_RX: begin
            if (tx_req[gi]) begin
              cnt_next = 4'd0;
              if (HAS_GUARD) state_next = ST_TX_GUARD;
              else           state_next = ST_TX;
            end
          end
          ST_TX_GUARD: begin
            if (!tx_req[gi]) begin
              state_next = ST_RX;
              cnt_next   = 4'd0;
            end else if (cnt_reg == GUARD_LAST) begin
              state_next = ST_TX;
              cnt_next   = 4'd0;
            end else begin
              cnt_next = cnt_reg + 4'd1;
            end
          end
          ST_TX: begin
            if (!tx_req[gi]) begin
              cnt_next = 4'd0;
              if (HAS_GUARD) state_next = ST_RX_GUARD;
              else           state_next = ST_RX;
            end
          end
          ST_RX_GUARD: begin
            // Requests are deliberately ignored until the line has settled back in RX.
            if (cnt_reg == GUARD_LAST) begin
              state_next = ST_RX;
              cnt_next   = 4'd0;
            end else begin
              cnt_next = cnt_reg + 4'd1;
            end
          end
          default: begin
            state_next = ST_RX;
            cnt_next   = 4'd0;
          end
        endcase
      end

      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          state_reg <= ST_RX;
          cnt_reg   <= 4'd0;
          tx_q_reg  <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          tx_q_reg  <= tx_data[gi];
        end
      end

      // Drive enable comes straight from the state register so reset releases the pads at once.
      assign drive      = (state_reg == ST_TX);
      assign io_p[gi]   = drive ? tx_q_reg  : 1'bz;
      assign io_n[gi]   = drive ? ~tx_q_reg : 1'bz;

      assign pair_valid = ((io_p[gi] === 1'b1) && (io_n[gi] === 1'b0)) ||
                          ((io_p[gi] === 1'b0) && (io_n[gi] === 1'b1));
      assign pair_bit   = (io_p[gi] === 1'b1);
      assign err_vec[gi] = (state_reg == ST_RX) && !pair_valid;

      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          rx_data_reg  <= 1'b0;
          rx_valid_reg <= 1'b0;
        end else if ((state_reg == ST_RX) && pair_valid) begin
          rx_data_reg  <= pair_bit;
          rx_valid_reg <= 1'b1;
        end else begin
          rx_valid_reg <= 1'b0;
        end
      end

      // A fresh error in the clearing cycle still leaves the flag set.
      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          err_flag_reg <= 1'b0;
        end else if (err_clear) begin
          err_flag_reg <= err_vec[gi];
        end else if (err_vec[gi]) begin
          err_flag_reg <= 1'b1;
        end
      end

      assign tx_active[gi] = drive;
      assign rx_data[gi]   = rx_data_reg;
      assign rx_valid[gi]  = rx_valid_reg;
      assign err_flag[gi]  = err_flag_reg;
    end
  endgenerate

  // One count per erroring cycle, however many channels err in it.
  assign any_err = |err_vec;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      err_count <= '0;
    end else if (err_clear) begin
      err_count <= any_err ? ERRW'(1) : '0;
    end else if (any_err && (err_count != {ERRW{1'b1}})) begin
      err_count <= err_count + ERRW'(1);
    end
  end

endmodule
